// File: rtl/key_entry.sv
`default_nettype none
// =====================================================================
// key_entry : keypad number-entry accumulator (magnitude x1000 + flags)
// Revision  : 1.0
// =====================================================================
module key_entry (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [24:0] data,
   output logic        neg,
   output logic        frac,
   output logic        error,
   output logic        value_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INT  = 2'd1,
      S_FRAC = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] c_KEY_9     = 4'd9;
   localparam logic [3:0] c_KEY_DOT   = 4'd10;
   localparam logic [3:0] c_KEY_SIGN  = 4'd11;
   localparam logic [3:0] c_KEY_CLEAR = 4'd12;
   localparam logic [3:0] c_KEY_ENTER = 4'd13;

   state_t      state_q, state_d;
   logic [13:0] int_q,   int_d;
   logic [2:0]  icnt_q,  icnt_d;
   logic [9:0]  fval_q,  fval_d;
   logic [1:0]  fcnt_q,  fcnt_d;
   logic        neg_q,   neg_d;
   logic        dot_q,   dot_d;
   logic        err_q,   err_d;
   logic        vv_q,    vv_d;
   logic [24:0] data_q,  data_d;
   logic [2:0]  w_limit;

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      icnt_d  = icnt_q;
      fval_d  = fval_q;
      fcnt_d  = fcnt_q;
      neg_d   = neg_q;
      dot_d   = dot_q;
      err_d   = 1'b0;
      vv_d    = 1'b0;
      w_limit = 3'd4;

      if (key_valid && key_code <= c_KEY_ENTER) begin
         // A new key after enter starts a fresh operand, then is applied normally.
         if (state_q == S_DONE && key_code != c_KEY_SIGN && key_code != c_KEY_ENTER) begin
            state_d = S_IDLE;
            int_d   = '0;
            icnt_d  = '0;
            fval_d  = '0;
            fcnt_d  = '0;
            neg_d   = 1'b0;
            dot_d   = 1'b0;
         end
         w_limit = neg_d ? 3'd3 : 3'd4;

         if (key_code <= c_KEY_9) begin
            if (state_d == S_FRAC) begin
               if (fcnt_d < 2'd3) begin
                  case (fcnt_d)
                     2'd0:    fval_d = fval_d + 10'(key_code) * 10'd100;
                     2'd1:    fval_d = fval_d + 10'(key_code) * 10'd10;
                     default: fval_d = fval_d + 10'(key_code);
                  endcase
                  fcnt_d = fcnt_d + 2'd1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (!(int_d == 14'd0 && key_code == 4'd0)) begin
               if (icnt_d < w_limit) begin
                  int_d   = int_d * 14'd10 + 14'(key_code);
                  icnt_d  = icnt_d + 3'd1;
                  state_d = S_INT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end else begin
            case (key_code)
               c_KEY_DOT: begin
                  if (state_d != S_FRAC) begin
                     dot_d   = 1'b1;
                     state_d = S_FRAC;
                  end
               end
               c_KEY_SIGN: begin
                  if (state_d != S_DONE && !neg_d && icnt_d == 3'd4) begin
                     err_d = 1'b1;
                  end else begin
                     neg_d = ~neg_d;
                  end
               end
               c_KEY_CLEAR: begin
                  state_d = S_IDLE;
                  int_d   = '0;
                  icnt_d  = '0;
                  fval_d  = '0;
                  fcnt_d  = '0;
                  neg_d   = 1'b0;
                  dot_d   = 1'b0;
               end
               c_KEY_ENTER: begin
                  vv_d    = 1'b1;
                  state_d = S_DONE;
               end
               default: ;
            endcase
         end
      end

      data_d = 25'(int_d) * 25'd1000 + 25'(fval_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         int_q   <= '0;
         icnt_q  <= '0;
         fval_q  <= '0;
         fcnt_q  <= '0;
         neg_q   <= 1'b0;
         dot_q   <= 1'b0;
         err_q   <= 1'b0;
         vv_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
         icnt_q  <= icnt_d;
         fval_q  <= fval_d;
         fcnt_q  <= fcnt_d;
         neg_q   <= neg_d;
         dot_q   <= dot_d;
         err_q   <= err_d;
         vv_q    <= vv_d;
         data_q  <= data_d;
      end
   end

   assign data        = data_q;
   assign neg         = neg_q;
   assign frac        = dot_q;
   assign error       = err_q;
   assign value_valid = vv_q;

endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// =====================================================================
// tb_key_entry : scoreboard bench for key_entry with a digit-list model
// Revision     : 1.0
// =====================================================================
module tb_key_entry;

   typedef struct packed {
      logic [24:0] data;
      logic        neg;
      logic        frac;
      logic        err;
      logic        vv;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [24:0] data;
   logic        neg;
   logic        frac;
   logic        error;
   logic        value_valid;

   int   n_vec;
   int   n_bad;
   exp_t sb_q[$];

   // reference model: operand kept as lists of entered digits
   int ip[$];
   int fp[$];
   bit m_neg;
   bit m_dot;
   bit m_done;

   key_entry u_dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .data        (data),
      .neg         (neg),
      .frac        (frac),
      .error       (error),
      .value_valid (value_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void mclear();
      ip.delete();
      fp.delete();
      m_neg  = 1'b0;
      m_dot  = 1'b0;
      m_done = 1'b0;
   endfunction

   function automatic exp_t model(input bit kv, input int k);
      exp_t e;
      int   iv;
      int   fv;
      int   wt[3];
      e   = '0;
      wt  = '{100, 10, 1};
      if (kv && k < 14) begin
         if (m_done && k != 11 && k != 13) mclear();
         if (k <= 9) begin
            if (m_dot) begin
               if (fp.size() < 3) fp.push_back(k);
               else e.err = 1'b1;
            end else if (!(ip.size() == 0 && k == 0)) begin
               if (ip.size() < (m_neg ? 3 : 4)) ip.push_back(k);
               else e.err = 1'b1;
            end
         end else if (k == 10) begin
            m_dot = 1'b1;
         end else if (k == 11) begin
            if (!m_done && !m_neg && ip.size() == 4) e.err = 1'b1;
            else m_neg = !m_neg;
         end else if (k == 12) begin
            mclear();
         end else begin
            e.vv   = 1'b1;
            m_done = 1'b1;
         end
      end
      iv = 0;
      foreach (ip[i]) iv = iv * 10 + ip[i];
      fv = 0;
      foreach (fp[i]) fv = fv + fp[i] * wt[i];
      e.data = 25'(iv * 1000 + fv);
      e.neg  = m_neg;
      e.frac = m_dot;
      return e;
   endfunction

   task automatic apply(input bit kv, input int k);
      @(negedge clk);
      key_valid = kv;
      key_code  = 4'(k);
      sb_q.push_back(model(kv, k));
   endtask

   task automatic keys(input int ks[$]);
      foreach (ks[i]) apply(1'b1, ks[i]);
      apply(1'b0, 0);
   endtask

   task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic async_reset();
      @(posedge clk);
      #4;
      key_valid = 1'b0;
      rst       = 1'b1;
      #2;
      check_now("async_rst", 32'({data, neg, frac, error, value_valid}), 32'd0);
      rst = 1'b0;
      mclear();
      sb_q.push_back(model(1'b0, 0));
   endtask

   // monitor: every edge produces an output set that is compared to the queue head
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if ({data, neg, frac, error, value_valid} !== e) begin
               n_bad++;
               $display("FAIL scoreboard t=%0t: got data=%0d neg=%b frac=%b err=%b vv=%b required data=%0d neg=%b frac=%b err=%b vv=%b",
                        $time, data, neg, frac, error, value_valid, e.data, e.neg, e.frac, e.err, e.vv);
            end
         end
      end
   end

   initial begin
      int r;
      n_vec     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'd0;
      mclear();
      #1;
      check_now("reset_state", 32'({data, neg, frac, error, value_valid}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      keys('{1, 2, 3, 10, 4, 5, 13});
      check_now("entry_data", 32'(data), 32'd123450);
      check_now("entry_frac", 32'(frac), 32'd1);

      keys('{12, 1, 2, 3, 4});
      check_now("int_limit4", 32'(data), 32'd1234000);
      keys('{5});
      check_now("int_over", 32'(data), 32'd1234000);

      keys('{12, 11, 1, 2, 3, 4});
      check_now("neg_limit3", 32'(data), 32'd123000);
      check_now("neg_flag", 32'(neg), 32'd1);

      keys('{12, 1, 2, 3, 4, 11});
      check_now("sign_reject", 32'(neg), 32'd0);

      keys('{12, 0, 0, 7, 10, 0, 0, 5, 9});
      check_now("frac_limit", 32'(data), 32'd7005);

      keys('{13, 9});
      check_now("done_digit", 32'(data), 32'd9000);
      check_now("done_frac", 32'(frac), 32'd0);
      keys('{13, 11});
      check_now("done_sign", 32'(neg), 32'd1);
      check_now("done_sign_data", 32'(data), 32'd9000);

      keys('{12, 1, 2});
      async_reset();
      keys('{10});
      check_now("dot_after_rst", 32'({data, frac}), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            apply(1'b0, int'($urandom_range(0, 15)));
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      apply(1'b1, int'($urandom_range(0, 9)));
            else if (r < 68) apply(1'b1, 10);
            else if (r < 76) apply(1'b1, 11);
            else if (r < 80) apply(1'b1, 12);
            else if (r < 92) apply(1'b1, 13);
            else             apply(1'b1, int'($urandom_range(14, 15)));
         end
      end
      apply(1'b0, 0);
      repeat (3) @(posedge clk);
      #3;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/key_entry.md
# key_entry

Keypad number-entry accumulator for the calculator datapath. Consumes one-cycle key events (digits, decimal point, sign, clear, enter) and builds the signed fixed-point operand that the display formatter renders. Produces a magnitude scaled by 1000, plus `neg`, `frac` and `error` flags, in exactly the format the display formatter consumes. It sits between the keypad debouncer/decoder and the display and ALU path.

## Interface
- No parameters. Limits are fixed: integer part max 4 digits (3 when negative), fraction max 3 digits.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is sampled on every edge where this is high.
- `key_code`  in  4  0–9 digit, 10 decimal point, 11 sign toggle, 12 clear, 13 enter, 14–15 ignored.
- `data`  out  25  magnitude ×1000 (thousandths units), range 0..9_999_999.
- `neg`  out  1  operand is negative.
- `frac`  out  1  decimal point has been entered for the current operand.
- `error`  out  1  one-cycle pulse: key rejected because a digit limit was reached.
- `value_valid`  out  1  one-cycle pulse: operand committed by enter.

## Operation
- Internal state: `int_val` (14 bit, 0..9999), `int_cnt` (0..4, significant integer digits), `frac_val` (10 bit, 0..999), `frac_cnt` (0..3).
- FSM states: IDLE, INT, FRAC, DONE. Reset enters IDLE with all values 0.
- `data` = `int_val`×1000 + `frac_val`. It is registered and updated on the same edge as the state.
- Digit d in IDLE or INT:
  - If `int_val`==0 and d==0: no change. A leading zero does not increment `int_cnt`.
  - Else if `int_cnt` < limit (4, or 3 when `neg`=1): `int_val` ← `int_val`×10+d, `int_cnt`+1, go to INT.
  - Else: no change, pulse `error`.
- Digit d in FRAC:
  - If `frac_cnt` < 3: add d×100, d×10 or d×1 for the 1st, 2nd or 3rd fraction digit; `frac_cnt`+1.
  - Else: pulse `error`.
- Decimal point:
  - In IDLE/INT: `frac` ← 1, go to FRAC.
  - In FRAC: ignored, no error.
- Sign toggle:
  - In IDLE/INT/FRAC: if `neg`=0 and `int_cnt`==4, reject and pulse `error`. Otherwise toggle `neg`.
  - In DONE: toggle `neg`, stay in DONE, no error.
- Clear: from any state, zero all values and flags, go to IDLE.
- Enter:
  - In IDLE/INT/FRAC: pulse `value_valid`, go to DONE; outputs hold.
  - In DONE: pulse `value_valid` again.
- Any key in DONE other than sign or enter first clears the operand, then applies the key in the same cycle:
  - Digit → new operand starts with that digit.
  - Decimal point → `data`=0, `frac`=1, FRAC.
  - Clear → IDLE.
- Codes 14–15: no state change, no pulse.

## Timing
- Reset values: `data`=0, `neg`=0, `frac`=0, `error`=0, `value_valid`=0, FSM=IDLE. Reset asserted mid-entry clears everything immediately, with no clock needed.
- Latency: a key sampled at edge N is reflected on all outputs after edge N (one-cycle registered).
- `error` and `value_valid` are high for exactly one cycle per accepting key event, never both in the same cycle.
- `key_valid` high on consecutive cycles means consecutive keys; there is no internal debouncing and no back-pressure.
- All arithmetic is unsigned. Overflow is impossible by construction: 9999×1000+999 < 2^25.

## Test plan
- Reset, then keys 1,2,3,.,4,5,enter → `data`=123450, `frac`=1, `neg`=0; `value_valid` high exactly one cycle after enter; no `error`.
- Keys 1,2,3,4,5 → `data`=1234000 after the 4th digit; the 5th digit pulses `error` and `data` stays 1234000.
- Keys sign,1,2,3,4 → `neg`=1, `data`=123000, `error` on the 4th digit. Separately, keys 1,2,3,4,sign → `error`, `neg` stays 0.
- Keys 0,0,7,.,0,0,5 → `data`=7005. Then a 4th fraction digit 9 → `error`, `data` unchanged.
- After enter with `data`=7005: key 9 → `data`=9000, `frac`=0, `neg`=0. Key sign in DONE → `neg` toggles, `data` unchanged.
- Mid-entry (`data`=12000), assert `rst` between edges → all outputs 0 immediately. After release, key . → `data`=0, `frac`=1.
